// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low digit patterns and the BCD decode helper.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_BLANK = 7'h7F;

    // {a,b,c,d,e,f,g}, a = MSB, 0 = segment lit
    localparam seg7_t SEG7_DIGIT [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    function automatic seg7_t seg7_decode(input logic [3:0] bcd);
        if (bcd > 4'd9)
            return SEG7_BLANK;
        return SEG7_DIGIT[bcd];
    endfunction

endpackage

// File: rtl/bcd_7seg_scan_driver_if.sv
// Datapath-side bus of the scan driver: load/data inputs and the registered pin outputs.
interface bcd_7seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      en;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   bcd_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      blank_lz;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_done;

    modport master (
        output en, load, bcd_in, dp_in, blank_lz,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  en, load, bcd_in, dp_in, blank_lz,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/bcd_to_seg7_dec.sv
// Combinational BCD digit to active-low segment pattern; codes 10..15 decode blank.
module bcd_to_seg7_dec
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output seg7_t      seg
);
    assign seg = seg7_decode(bcd);
endmodule

// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: shadow capture, slot prescaler, digit scan,
// leading-zero blanking and a one-cycle dark gap at the start of every slot.
module bcd_7seg_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input logic                    clk,
    input logic                    rst,
    bcd_7seg_scan_driver_if.slave  bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam seg7_t                 SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ?
                                                {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic  [NUM_DIGITS-1:0][3:0] shadow_bcd;
    logic  [NUM_DIGITS-1:0]      shadow_dp;
    logic  [CNT_W-1:0]           cnt;
    logic  [IDX_W-1:0]           idx;
    seg7_t [NUM_DIGITS-1:0]      dec_seg;
    logic  [NUM_DIGITS-1:0]      blank_mask;
    logic  [NUM_DIGITS-1:0]      an_sel;
    logic                        slot_end;
    logic                        frame_end;
    logic                        lz_run;

    seg7_t                       seg_n;
    logic                        dp_n;
    logic  [NUM_DIGITS-1:0]      an_n;
    seg7_t                       seg_q;
    logic                        dp_q;
    logic  [NUM_DIGITS-1:0]      an_q;
    logic                        frame_done_q;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_to_seg7_dec u_dec (
            .bcd (shadow_bcd[i]),
            .seg (dec_seg[i])
        );
    end

    // Digit i>0 is a leading zero when it and every digit above it is exactly 4'h0.
    always_comb begin
        lz_run     = 1'b1;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz_run        = lz_run && (shadow_bcd[i] == 4'h0);
            blank_mask[i] = bus.blank_lz && lz_run;
        end
    end

    assign slot_end  = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
    assign an_sel    = NUM_DIGITS'(1) << idx;

    // cnt==0 is the anti-ghost gap: anodes released while the segment pattern changes.
    always_comb begin
        seg_n = SEG_OFF;
        dp_n  = DP_OFF;
        an_n  = AN_OFF;
        if (bus.en && (cnt != '0)) begin
            an_n  = (AN_ACTIVE_LOW != 0) ? ~an_sel : an_sel;
            seg_n = blank_mask[idx] ? SEG7_BLANK : dec_seg[idx];
            if (SEG_ACTIVE_LOW == 0)
                seg_n = ~seg_n;
            dp_n  = (SEG_ACTIVE_LOW != 0) ? ~shadow_dp[idx] : shadow_dp[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_bcd   <= '0;
            shadow_dp    <= '0;
            cnt          <= '0;
            idx          <= '0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow_bcd <= bus.bcd_in;
                shadow_dp  <= bus.dp_in;
            end
            if (bus.en) begin
                if (slot_end) begin
                    cnt <= '0;
                    idx <= frame_end ? '0 : idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            seg_q        <= seg_n;
            dp_q         <= dp_n;
            an_q         <= an_n;
            frame_done_q <= bus.en && frame_end;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Directed bench for bcd_7seg_scan_driver with 4 digits and a 4-cycle slot.
module tb_bcd_7seg_scan_driver;
    localparam int ND = 4;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0;
    int   total    = 0;

    bcd_7seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    bcd_7seg_scan_driver #(
        .NUM_DIGITS     (ND),
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b0;
        bus.load = 1'b0;
        bus.bcd_in = '0;
        bus.dp_in = '0;
        bus.blank_lz = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (bus.seg !== 7'h7F || bus.dp !== 1'b1 || bus.an !== 4'hF || bus.frame_done !== 1'b0)
                $display("FAIL reset cyc=%0d got seg=%b dp=%b an=%b fd=%b want seg=1111111 dp=1 an=1111 fd=0",
                         k, bus.seg, bus.dp, bus.an, bus.frame_done);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_scan();
        logic [3:0] e_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] e_seg [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        logic       e_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0] xa;
        logic [6:0] xs;
        logic       xd;
        logic       xf;
        rst = 1'b0;
        bus.en = 1'b1;
        bus.load = 1'b1;
        bus.bcd_in = 16'h1234;
        bus.dp_in = 4'b0100;
        for (int k = 1; k <= 32; k++) begin
            step();
            bus.load = 1'b0;
            if ((k - 1) % 4 == 0) begin
                xa = 4'hF; xs = 7'h7F; xd = 1'b1;
            end else begin
                xa = e_an[((k - 1) / 4) % 4];
                xs = e_seg[((k - 1) / 4) % 4];
                xd = e_dp[((k - 1) / 4) % 4];
            end
            xf = (k == 16 || k == 32);
            total++;
            if (bus.an !== xa || bus.seg !== xs || bus.dp !== xd || bus.frame_done !== xf)
                $display("FAIL scan cyc=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                         k, bus.an, bus.seg, bus.dp, bus.frame_done, xa, xs, xd, xf);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_blank();
        logic [3:0] e_an   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] e_lz1  [4] = '{7'b0000001, 7'b0001111, 7'h7F, 7'h7F};
        logic [6:0] e_lz0  [4] = '{7'b0000001, 7'b0001111, 7'b0000001, 7'b0000001};
        logic [3:0] xa;
        logic [6:0] xs;
        bus.load = 1'b1;
        bus.bcd_in = 16'h0070;
        bus.dp_in = 4'b0000;
        for (int pass = 0; pass < 2; pass++) begin
            bus.blank_lz = (pass == 0);
            for (int k = 1; k <= 16; k++) begin
                step();
                bus.load = 1'b0;
                if ((k - 1) % 4 == 0) begin
                    xa = 4'hF; xs = 7'h7F;
                end else begin
                    xa = e_an[(k - 1) / 4];
                    xs = (pass == 0) ? e_lz1[(k - 1) / 4] : e_lz0[(k - 1) / 4];
                end
                total++;
                if (bus.an !== xa || bus.seg !== xs || bus.dp !== 1'b1)
                    $display("FAIL blank_lz=%0d cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=1",
                             1 - pass, k, bus.an, bus.seg, bus.dp, xa, xs);
                else
                    pass_cnt++;
            end
        end
    endtask

    task automatic test_blank_invalid();
        logic [3:0] e_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0] xa;
        bus.load = 1'b1;
        bus.bcd_in = 16'h00AF;
        bus.blank_lz = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            bus.load = 1'b0;
            xa = ((k - 1) % 4 == 0) ? 4'hF : e_an[(k - 1) / 4];
            total++;
            if (bus.an !== xa || bus.seg !== 7'h7F)
                $display("FAIL invalid_codes cyc=%0d got an=%b seg=%b want an=%b seg=1111111",
                         k, bus.an, bus.seg, xa);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_enable();
        bus.load = 1'b1;
        bus.bcd_in = 16'h1234;
        bus.dp_in = 4'b0100;
        bus.blank_lz = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            bus.load = 1'b0;
        end
        total++;
        if (bus.an !== 4'b1011 || bus.seg !== 7'b0010010 || bus.dp !== 1'b0)
            $display("FAIL pre_freeze got an=%b seg=%b dp=%b want an=1011 seg=0010010 dp=0",
                     bus.an, bus.seg, bus.dp);
        else
            pass_cnt++;
        bus.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                bus.load = 1'b1;
                bus.bcd_in = 16'h5678;
                bus.dp_in = 4'b0000;
            end
            step();
            bus.load = 1'b0;
            total++;
            if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1 || bus.frame_done !== 1'b0)
                $display("FAIL frozen cyc=%0d got an=%b seg=%b dp=%b fd=%b want an=1111 seg=1111111 dp=1 fd=0",
                         k, bus.an, bus.seg, bus.dp, bus.frame_done);
            else
                pass_cnt++;
        end
        bus.en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            logic [3:0] xa;
            logic [6:0] xs;
            step();
            case (k)
                1, 2:    begin xa = 4'b1011; xs = 7'b0100000; end
                3:       begin xa = 4'hF;    xs = 7'h7F;      end
                default: begin xa = 4'b0111; xs = 7'b0100100; end
            endcase
            total++;
            if (bus.an !== xa || bus.seg !== xs || bus.dp !== 1'b1)
                $display("FAIL resume cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=1",
                         k, bus.an, bus.seg, bus.dp, xa, xs);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_rst_mid();
        for (int k = 0; k < 12; k++)
            step();
        total++;
        if (bus.an !== 4'b1011 || bus.seg !== 7'b0100000)
            $display("FAIL pre_reset got an=%b seg=%b want an=1011 seg=0100000", bus.an, bus.seg);
        else
            pass_cnt++;
        rst = 1'b1;
        bus.blank_lz = 1'b1;
        bus.load = 1'b1;
        bus.bcd_in = 16'h1234;
        step();
        total++;
        if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1 || bus.frame_done !== 1'b0)
            $display("FAIL mid_reset got an=%b seg=%b dp=%b fd=%b want an=1111 seg=1111111 dp=1 fd=0",
                     bus.an, bus.seg, bus.dp, bus.frame_done);
        else
            pass_cnt++;
        rst = 1'b0;
        bus.load = 1'b0;
        step();
        total++;
        if (bus.an !== 4'hF || bus.seg !== 7'h7F)
            $display("FAIL restart_gap got an=%b seg=%b want an=1111 seg=1111111", bus.an, bus.seg);
        else
            pass_cnt++;
        step();
        total++;
        if (bus.an !== 4'b1110 || bus.seg !== 7'b0000001 || bus.dp !== 1'b1)
            $display("FAIL restart_digit0 got an=%b seg=%b dp=%b want an=1110 seg=0000001 dp=1",
                     bus.an, bus.seg, bus.dp);
        else
            pass_cnt++;
        for (int k = 0; k < 4; k++)
            step();
        total++;
        if (bus.an !== 4'b1101 || bus.seg !== 7'h7F)
            $display("FAIL restart_digit1 got an=%b seg=%b want an=1101 seg=1111111", bus.an, bus.seg);
        else
            pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank();
        test_blank_invalid();
        test_enable();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
